// File: rtl/bfly_stage_ctrl.sv
// -----------------------------------------------------------------------------
// bfly_stage_ctrl
//
// Sequencing controller for one radix-2 single-delay-feedback butterfly stage
// of the 512-point FFT datapath. One beat carries NUM parallel samples; a
// frame is COUNT beats. The first HALF beats of a frame fill the delay buffer.
// The second HALF beats run the butterfly: the sum is emitted and the
// difference is written back into the buffer. The stored differences leave
// during the FILL half of the next frame, or through FLUSH when no frame
// follows.
//
// Handshake: there is no backpressure. valid_in marks a beat in the cycle it is
// high. sof is only meaningful together with valid_in. valid_out marks an
// output beat. out_sel and frame_done are only meaningful with valid_out.
//
// Ports
//   clk, rstn     clock, asynchronous active-low reset
//   valid_in      input beat present this cycle
//   sof           start of frame (qualified by valid_in)
//   flush         single-cycle request to drain pending differences
//   buf_wr        delay buffer write strobe (combinational)
//   buf_rd        delay buffer read strobe (combinational)
//   bfly_en       butterfly compute enable (combinational)
//   tw_addr       twiddle ROM index, registered so it lines up with the
//                 multiplier input
//   out_sel       output mux: 0 = sum path, 1 = stored difference path
//   valid_out     stage output beat valid
//   frame_done    one-cycle pulse on the last difference beat of a frame
//   busy          FSM not in IDLE
//   err_sync      sticky flag: sof seen in the middle of a frame
//   frame_cnt     completed-frame count, saturating (statistics build only)
//   state_dbg     current FSM state: 0 IDLE, 1 FILL, 2 CALC, 3 FLUSH
//
// Configuration macro
//   BFLY_CTRL_STATS_EN  when defined, frame_cnt counts frame_done pulses and
//                       saturates at 16'hFFFF. When undefined, frame_cnt is
//                       tied to zero and no counter is built.
// -----------------------------------------------------------------------------
module bfly_stage_ctrl #(
  parameter int DATA     = 512,
  parameter int NUM      = 16,
  parameter int COUNT    = DATA / NUM,
  parameter int HALF     = COUNT / 2,
  parameter int BFLY_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    valid_in,
  input  logic                    sof,
  input  logic                    flush,
  output logic                    buf_wr,
  output logic                    buf_rd,
  output logic                    bfly_en,
  output logic [$clog2(HALF)-1:0] tw_addr,
  output logic                    out_sel,
  output logic                    valid_out,
  output logic                    frame_done,
  output logic                    busy,
  output logic                    err_sync,
  output logic [15:0]             frame_cnt,
  output logic [1:0]              state_dbg
);

  localparam int CW = $clog2(COUNT);
  localparam int TW = $clog2(HALF);

  localparam logic [CW-1:0] CNT_HALF      = CW'(HALF);
  localparam logic [CW-1:0] CNT_FILL_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_LAST      = CW'(COUNT - 1);
  localparam logic [TW-1:0] DIFF_LAST     = TW'(HALF - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_CALC  = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;     // beat position inside the frame
  logic          pend_q, pend_d;   // stored differences still to be emitted
  logic [TW-1:0] dcnt_q, dcnt_d;   // differences already emitted from this set
  logic [TW-1:0] tw_q, tw_d;
  logic          err_q, err_d;

  // Per-cycle decisions, before the output delay pipeline.
  logic          beat;
  logic          wr_c, rd_c, en_c;
  logic          emit_v, emit_sel, emit_done;

  // Output delay pipeline; stage BFLY_LAT-1 drives the ports.
  logic [BFLY_LAT-1:0] pv_q, ps_q, pd_q;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      dcnt_q  <= '0;
      tw_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      dcnt_q  <= dcnt_d;
      tw_q    <= tw_d;
      err_q   <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state, strobes and emission decisions
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    dcnt_d    = dcnt_q;
    tw_d      = tw_q;
    err_d     = err_q;
    beat      = 1'b0;
    wr_c      = 1'b0;
    rd_c      = 1'b0;
    en_c      = 1'b0;
    emit_v    = 1'b0;
    emit_sel  = 1'b0;
    emit_done = 1'b0;

    // First, decide whether a beat is taken this cycle and at which position.
    // The sof beat that leaves IDLE is beat 0 of the frame, so it is taken as
    // an ordinary FILL beat and its samples go into the delay buffer.
    case (state_q)
      S_IDLE: begin
        if (valid_in && sof) begin
          beat  = 1'b1;
          cnt_d = '0;
        end
      end
      S_FILL, S_CALC: begin
        if (valid_in) begin
          beat = 1'b1;
          // sof in the middle of a frame: restart at beat 0 and throw away
          // any differences that were still waiting to be emitted.
          if (sof && (cnt_q != '0)) begin
            err_d  = 1'b1;
            pend_d = 1'b0;
            dcnt_d = '0;
            cnt_d  = '0;
          end
        end
      end
      S_FLUSH: begin
        // One stored difference per cycle; input beats are dropped.
        rd_c     = 1'b1;
        emit_v   = 1'b1;
        emit_sel = 1'b1;
        if (dcnt_q == DIFF_LAST) begin
          emit_done = 1'b1;
          pend_d    = 1'b0;
          dcnt_d    = '0;
          cnt_d     = '0;
          state_d   = S_IDLE;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Then process the beat at position cnt_d.
    if (beat) begin
      if (cnt_d < CNT_HALF) begin
        // FILL half: store the new samples; the slot being overwritten holds
        // a difference from the previous frame, which is read out and
        // emitted when one is pending.
        wr_c = 1'b1;
        rd_c = 1'b1;
        if (pend_d) begin
          emit_v   = 1'b1;
          emit_sel = 1'b1;
          if (dcnt_d == DIFF_LAST) begin
            emit_done = 1'b1;
            pend_d    = 1'b0;
            dcnt_d    = '0;
          end else begin
            dcnt_d = dcnt_d + 1'b1;
          end
        end
        state_d = (cnt_d == CNT_FILL_LAST) ? S_CALC : S_FILL;
      end else begin
        // CALC half: butterfly against the stored sample; the sum leaves
        // now and the difference goes back into the same buffer slot.
        wr_c   = 1'b1;
        rd_c   = 1'b1;
        en_c   = 1'b1;
        emit_v = 1'b1;
        tw_d   = TW'(cnt_d - CNT_HALF);
        if (cnt_d == CNT_LAST) begin
          pend_d  = 1'b1;
          dcnt_d  = '0;
          state_d = S_FILL;
        end else begin
          state_d = S_CALC;
        end
      end
      cnt_d = (cnt_d == CNT_LAST) ? '0 : cnt_d + 1'b1;
    end

    // A flush is only taken if differences are still pending after this
    // cycle's beat, so a beat arriving with the flush is processed first.
    if ((state_q != S_FLUSH) && flush && pend_d) begin
      state_d = S_FLUSH;
    end
  end

  // ---------------------------------------------------------------------------
  // Output delay pipeline, matching the butterfly latency
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pv_q <= '0;
      ps_q <= '0;
      pd_q <= '0;
    end else begin
      pv_q[0] <= emit_v;
      ps_q[0] <= emit_sel;
      pd_q[0] <= emit_done;
      for (int i = 1; i < BFLY_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        ps_q[i] <= ps_q[i-1];
        pd_q[i] <= pd_q[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Completed-frame statistics
  // ---------------------------------------------------------------------------
`ifdef BFLY_CTRL_STATS_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_cnt_q <= '0;
    end else if (frame_done && (frame_cnt_q != 16'hFFFF)) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = 16'd0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // The strobes are gated by rstn so the buffer sees nothing while reset is
  // held, even if the upstream keeps presenting beats.
  assign buf_wr     = wr_c & rstn;
  assign buf_rd     = rd_c & rstn;
  assign bfly_en    = en_c & rstn;
  assign tw_addr    = tw_q;
  assign valid_out  = pv_q[BFLY_LAT-1];
  assign out_sel    = ps_q[BFLY_LAT-1];
  assign frame_done = pd_q[BFLY_LAT-1];
  assign busy       = (state_q != S_IDLE);
  assign err_sync   = err_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_bfly_stage_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bfly_stage_ctrl
//
// Bench for bfly_stage_ctrl with default parameters (COUNT=32, HALF=16,
// BFLY_LAT=1). Stimulus is a queue of {valid_in, sof, flush} triples per
// cycle. A frame-level model tracks beat position, the number of differences
// still owed and whether a flush is draining, and produces the expected
// strobes, output beats (through exp_q) and registered outputs.
// -----------------------------------------------------------------------------
module tb_bfly_stage_ctrl;

  localparam int COUNT = 32;
  localparam int HALF  = 16;
  localparam int LAT   = 1;
`ifdef BFLY_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        valid_in = 1'b0;
  logic        sof = 1'b0;
  logic        flush = 1'b0;
  logic        buf_wr, buf_rd, bfly_en, out_sel, valid_out, frame_done;
  logic        busy, err_sync;
  logic [3:0]  tw_addr;
  logic [15:0] frame_cnt;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  bfly_stage_ctrl dut (
    .clk        (clk),
    .rstn       (rstn),
    .valid_in   (valid_in),
    .sof        (sof),
    .flush      (flush),
    .buf_wr     (buf_wr),
    .buf_rd     (buf_rd),
    .bfly_en    (bfly_en),
    .tw_addr    (tw_addr),
    .out_sel    (out_sel),
    .valid_out  (valid_out),
    .frame_done (frame_done),
    .busy       (busy),
    .err_sync   (err_sync),
    .frame_cnt  (frame_cnt),
    .state_dbg  (state_dbg)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------------------------------------------------------------------
  // Reference model and scoreboard
  // ---------------------------------------------------------------------------
  bit         m_active;    // inside a frame
  bit         m_flushing;  // draining differences with no input
  bit         m_err;
  int         m_pos;       // next beat position in the frame
  int         m_pend;      // differences still owed from the last frame
  int         m_tw;
  int         m_frames;
  logic [2:0] exp_q[$];    // {valid, sel, done} waiting for the output port
  logic [2:0] exp_strb;    // {buf_wr, buf_rd, bfly_en}
  logic [2:0] exp_out;     // {valid_out, out_sel, frame_done}
  logic [2:0] obs_strb;
  logic [2:0] stim_q[$];   // {valid_in, sof, flush}
  int         n_sum, n_diff, n_done, done_at, first_v;

  function automatic logic [21:0] exp_regs();
    return {4'(m_tw), (m_active || m_flushing), m_err, (STATS ? 16'(m_frames) : 16'd0)};
  endfunction

  task automatic model_reset();
    m_active = 0; m_flushing = 0; m_err = 0;
    m_pos = 0; m_pend = 0; m_tw = 0; m_frames = 0;
    exp_out = 3'b000;
    exp_q.delete();
    // The pipeline register itself supplies one cycle of delay.
    repeat (LAT - 1) exp_q.push_back(3'b000);
  endtask

  task automatic model_cycle(input bit v, input bit s, input bit f);
    bit emit, esel, edone;
    emit = 0; esel = 0; edone = 0;
    exp_strb = 3'b000;
    // frame_cnt follows a frame_done by one clock.
    if (exp_out[0] && m_frames < 65535) m_frames++;
    if (m_flushing) begin
      exp_strb = 3'b010;
      emit = 1; esel = 1;
      m_pend--;
      if (m_pend == 0) begin
        edone = 1; m_flushing = 0; m_active = 0; m_pos = 0;
      end
    end else begin
      if (v && s) begin
        if (m_active && m_pos != 0) begin
          m_err = 1; m_pend = 0;
        end
        m_active = 1; m_pos = 0;
      end
      if (v && m_active) begin
        if (m_pos < HALF) begin
          exp_strb = 3'b110;
          if (m_pend > 0) begin
            emit = 1; esel = 1;
            m_pend--;
            edone = (m_pend == 0);
          end
        end else begin
          exp_strb = 3'b111;
          emit = 1;
          m_tw = m_pos - HALF;
          if (m_pos == COUNT - 1) m_pend = HALF;
        end
        m_pos = (m_pos + 1) % COUNT;
      end
      if (f && m_pend > 0) m_flushing = 1;
    end
    exp_q.push_back({emit, esel, edone});
    exp_out = exp_q.pop_front();
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (inputs change on the falling edge)
  // ---------------------------------------------------------------------------
  task automatic apply_reset();
    rstn = 1'b0; valid_in = 0; sof = 0; flush = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic add(input int n, input logic [2:0] st);
    repeat (n) stim_q.push_back(st);
  endtask

  task automatic add_frame();
    add(1, 3'b110);
    add(COUNT - 1, 3'b100);
  endtask

  task automatic step(input logic [2:0] st);
    valid_in = st[2]; sof = st[1]; flush = st[0];
    model_cycle(st[2], st[1], st[0]);
    #1 obs_strb = {buf_wr, buf_rd, bfly_en};
    @(negedge clk);
    if (valid_out && !out_sel) n_sum++;
    if (valid_out && out_sel) n_diff++;
    if (valid_out && first_v < 0) first_v = n_sum + n_diff > 0 ? first_v : first_v;
    if (frame_done) n_done++;
  endtask

  task automatic clear_tally();
    stim_q.delete();
    n_sum = 0; n_diff = 0; n_done = 0; done_at = -1; first_v = -1;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rstn = 1'b0; valid_in = 1; sof = 1; flush = 1;
    #3;
    n_tests++;
    if ({buf_wr, buf_rd, bfly_en, tw_addr, out_sel, valid_out, frame_done,
         busy, err_sync, frame_cnt, state_dbg} !== 30'd0) begin
      n_fail++;
      $display("FAIL reset_held: got wr%b rd%b en%b tw%0d out%b%b%b busy%b err%b fc%0d st%0d, want all 0",
               buf_wr, buf_rd, bfly_en, tw_addr, valid_out, out_sel, frame_done,
               busy, err_sync, frame_cnt, state_dbg);
    end
    apply_reset();
    #1;
    n_tests++;
    if ({buf_wr, buf_rd, bfly_en, tw_addr, out_sel, valid_out, frame_done,
         busy, err_sync, frame_cnt, state_dbg} !== 30'd0) begin
      n_fail++;
      $display("FAIL reset_release: got busy%b err%b st%0d tw%0d fc%0d, want all 0",
               busy, err_sync, state_dbg, tw_addr, frame_cnt);
    end
    @(negedge clk);
  endtask

  task automatic test_single_frame();
    apply_reset();
    clear_tally();
    add_frame();
    add(1, 3'b001);
    add(20, 3'b000);
    foreach (stim_q[i]) begin
      step(stim_q[i]);
      if (valid_out && first_v < 0) first_v = i;
      if (frame_done) done_at = i;
      n_tests++;
      if (obs_strb !== exp_strb) begin
        n_fail++;
        $display("FAIL single_strobes cyc %0d: got %b want %b", i, obs_strb, exp_strb);
      end
      n_tests++;
      if ({valid_out, out_sel, frame_done} !== exp_out) begin
        n_fail++;
        $display("FAIL single_out cyc %0d: got %b want %b", i, {valid_out, out_sel, frame_done}, exp_out);
      end
      n_tests++;
      if ({tw_addr, busy, err_sync, frame_cnt} !== exp_regs()) begin
        n_fail++;
        $display("FAIL single_regs cyc %0d: got %h want %h", i, {tw_addr, busy, err_sync, frame_cnt}, exp_regs());
      end
    end
    n_tests++;
    if (n_sum != 16 || n_diff != 16 || n_done != 1) begin
      n_fail++;
      $display("FAIL single_counts: sum %0d diff %0d done %0d, want 16 16 1", n_sum, n_diff, n_done);
    end
    n_tests++;
    if (first_v != 16 || done_at != 48) begin
      n_fail++;
      $display("FAIL single_timing: first valid_out cyc %0d done cyc %0d, want 16 48", first_v, done_at);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    clear_tally();
    add_frame();
    add_frame();
    add(20, 3'b000);
    foreach (stim_q[i]) begin
      step(stim_q[i]);
      if (frame_done) done_at = i;
      n_tests++;
      if (obs_strb !== exp_strb) begin
        n_fail++;
        $display("FAIL b2b_strobes cyc %0d: got %b want %b", i, obs_strb, exp_strb);
      end
      n_tests++;
      if ({valid_out, out_sel, frame_done} !== exp_out) begin
        n_fail++;
        $display("FAIL b2b_out cyc %0d: got %b want %b", i, {valid_out, out_sel, frame_done}, exp_out);
      end
      n_tests++;
      if ({tw_addr, busy, err_sync, frame_cnt} !== exp_regs()) begin
        n_fail++;
        $display("FAIL b2b_regs cyc %0d: got %h want %h", i, {tw_addr, busy, err_sync, frame_cnt}, exp_regs());
      end
    end
    n_tests++;
    if (n_sum != 32 || n_diff != 16 || n_done != 1 || done_at != 47) begin
      n_fail++;
      $display("FAIL b2b_counts: sum %0d diff %0d done %0d at %0d, want 32 16 1 at 47",
               n_sum, n_diff, n_done, done_at);
    end
  endtask

  task automatic test_gapped();
    int tw_bad;
    int k;
    apply_reset();
    clear_tally();
    tw_bad = 0;
    k = 0;
    add(1, 3'b110);
    add(1, 3'b000);
    for (int b = 1; b < COUNT; b++) begin
      add(1, 3'b100);
      add(1, 3'b000);
    end
    add(1, 3'b001);
    add(20, 3'b000);
    foreach (stim_q[i]) begin
      step(stim_q[i]);
      if (valid_out && !out_sel) begin
        if (tw_addr != 4'(k)) tw_bad++;
        k++;
      end
      n_tests++;
      if (obs_strb !== exp_strb) begin
        n_fail++;
        $display("FAIL gap_strobes cyc %0d: got %b want %b", i, obs_strb, exp_strb);
      end
      n_tests++;
      if ({valid_out, out_sel, frame_done} !== exp_out) begin
        n_fail++;
        $display("FAIL gap_out cyc %0d: got %b want %b", i, {valid_out, out_sel, frame_done}, exp_out);
      end
      n_tests++;
      if ({tw_addr, busy, err_sync, frame_cnt} !== exp_regs()) begin
        n_fail++;
        $display("FAIL gap_regs cyc %0d: got %h want %h", i, {tw_addr, busy, err_sync, frame_cnt}, exp_regs());
      end
    end
    n_tests++;
    if (n_sum != 16 || n_diff != 16 || n_done != 1 || tw_bad != 0) begin
      n_fail++;
      $display("FAIL gap_counts: sum %0d diff %0d done %0d tw_bad %0d, want 16 16 1 0",
               n_sum, n_diff, n_done, tw_bad);
    end
  endtask

  task automatic test_misaligned();
    apply_reset();
    clear_tally();
    add_frame();            // leaves 16 differences pending
    add(1, 3'b110);
    add(9, 3'b100);         // beat position now 10, 10 differences emitted
    add(1, 3'b110);         // misaligned sof
    add(15, 3'b100);        // restarted frame reaches beat 16
    add(5, 3'b000);
    foreach (stim_q[i]) begin
      step(stim_q[i]);
      n_tests++;
      if (obs_strb !== exp_strb) begin
        n_fail++;
        $display("FAIL sync_strobes cyc %0d: got %b want %b", i, obs_strb, exp_strb);
      end
      n_tests++;
      if ({valid_out, out_sel, frame_done} !== exp_out) begin
        n_fail++;
        $display("FAIL sync_out cyc %0d: got %b want %b", i, {valid_out, out_sel, frame_done}, exp_out);
      end
      n_tests++;
      if ({tw_addr, busy, err_sync, frame_cnt} !== exp_regs()) begin
        n_fail++;
        $display("FAIL sync_regs cyc %0d: got %h want %h", i, {tw_addr, busy, err_sync, frame_cnt}, exp_regs());
      end
    end
    n_tests++;
    if (err_sync !== 1'b1 || n_done != 0 || n_diff != 10 || state_dbg !== 2'd2) begin
      n_fail++;
      $display("FAIL sync_summary: err %b done %0d diff %0d state %0d, want 1 0 10 2",
               err_sync, n_done, n_diff, state_dbg);
    end
  endtask

  task automatic test_reset_mid_calc();
    apply_reset();
    clear_tally();
    add(1, 3'b110);
    add(19, 3'b100);        // beat position 20, inside CALC
    foreach (stim_q[i]) step(stim_q[i]);
    n_tests++;
    if (busy !== 1'b1 || valid_out !== 1'b1 || state_dbg !== 2'd2) begin
      n_fail++;
      $display("FAIL midcalc_pre: busy %b valid_out %b state %0d, want 1 1 2", busy, valid_out, state_dbg);
    end
    valid_in = 1; sof = 1;
    #2 rstn = 1'b0;
    #1;
    n_tests++;
    if ({buf_wr, buf_rd, bfly_en, tw_addr, out_sel, valid_out, frame_done,
         busy, err_sync, frame_cnt, state_dbg} !== 30'd0) begin
      n_fail++;
      $display("FAIL midcalc_in_reset: wr%b rd%b en%b tw%0d vo%b busy%b st%0d, want all 0",
               buf_wr, buf_rd, bfly_en, tw_addr, valid_out, busy, state_dbg);
    end
    model_reset();
    repeat (2) @(negedge clk);
    valid_in = 0; sof = 0;
    rstn = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({buf_wr, buf_rd, bfly_en, tw_addr, out_sel, valid_out, frame_done,
         busy, err_sync, frame_cnt, state_dbg} !== 30'd0) begin
      n_fail++;
      $display("FAIL midcalc_after: tw%0d vo%b busy%b err%b st%0d, want all 0",
               tw_addr, valid_out, busy, err_sync, state_dbg);
    end
  endtask

  task automatic test_random();
    bit v, s, f;
    apply_reset();
    clear_tally();
    for (int i = 0; i < 1200; i++) begin
      v = ($urandom_range(0, 3) != 0);
      s = v && (m_active ? ($urandom_range(0, 63) == 0) : ($urandom_range(0, 3) == 0));
      f = ($urandom_range(0, 40) == 0);
      step({v, s, f});
      n_tests++;
      if (obs_strb !== exp_strb) begin
        n_fail++;
        $display("FAIL rand_strobes cyc %0d: got %b want %b", i, obs_strb, exp_strb);
      end
      n_tests++;
      if ({valid_out, out_sel, frame_done} !== exp_out) begin
        n_fail++;
        $display("FAIL rand_out cyc %0d: got %b want %b", i, {valid_out, out_sel, frame_done}, exp_out);
      end
      n_tests++;
      if ({tw_addr, busy, err_sync, frame_cnt} !== exp_regs()) begin
        n_fail++;
        $display("FAIL rand_regs cyc %0d: got %h want %h", i, {tw_addr, busy, err_sync, frame_cnt}, exp_regs());
      end
    end
  endtask

  task automatic test_stats();
    apply_reset();
    clear_tally();
    repeat (3) begin
      add_frame();
      add(1, 3'b001);
      add(20, 3'b000);
    end
    foreach (stim_q[i]) begin
      step(stim_q[i]);
      n_tests++;
      if ({valid_out, out_sel, frame_done} !== exp_out) begin
        n_fail++;
        $display("FAIL stats_out cyc %0d: got %b want %b", i, {valid_out, out_sel, frame_done}, exp_out);
      end
    end
    n_tests++;
    if (frame_cnt !== (STATS ? 16'd3 : 16'd0) || n_done != 3) begin
      n_fail++;
      $display("FAIL stats_frame_cnt: got %0d (done pulses %0d), want %0d (3)",
               frame_cnt, n_done, STATS ? 3 : 0);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and final report
  // ---------------------------------------------------------------------------
  initial begin
    model_reset();
    clear_tally();
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_gapped();
    test_misaligned();
    test_reset_mid_calc();
    test_random();
    test_stats();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bfly_stage_ctrl.md
# bfly_stage_ctrl

Sequencing controller for one radix-2 single-delay-feedback (SDF) butterfly stage of the 512-point FFT datapath. It tracks beat position within each frame; one beat is NUM parallel samples. It drives the delay-buffer write/read strobes, butterfly enable, output mux select and twiddle ROM address. It also flushes the stored difference half of the last frame when no further frame follows. It sits between the input sample stream and the stage's delay buffer, butterfly and twiddle multiplier.

## Interface
- DATA, 512, points per frame
- NUM, 16, samples per beat (parallel lines)
- COUNT, DATA/NUM, beats per frame (32)
- HALF, COUNT/2, beats per half frame and delay depth (16)
- BFLY_LAT, 1, butterfly pipeline latency in cycles (1..4)

- clk  in  1  clock
- rstn  in  1  asynchronous, active-low reset
- valid_in  in  1  input beat present this cycle
- sof  in  1  start of frame, qualified by valid_in
- flush  in  1  single-cycle request to drain pending differences
- buf_wr  out  1  delay buffer write strobe, combinational
- buf_rd  out  1  delay buffer read strobe, combinational
- bfly_en  out  1  butterfly compute enable, combinational
- tw_addr  out  $clog2(HALF)  twiddle ROM index, registered
- out_sel  out  1  output mux: 0 = sum path, 1 = stored difference path
- valid_out  out  1  stage output beat valid
- frame_done  out  1  one-cycle pulse on the last output beat of a frame
- busy  out  1  FSM not in IDLE
- err_sync  out  1  sticky misaligned-sof flag
- frame_cnt  out  16  completed frame count (see Configuration)

## Operation
- Beat counter cnt is $clog2(COUNT) bits. It advances only on valid_in and wraps COUNT-1 -> 0.
- pend flag: set on the last beat of the CALC phase. Cleared when HALF difference beats have been emitted.
- The FSM has four states: IDLE, FILL, CALC, FLUSH.
- IDLE:
  - All outputs are deasserted.
  - valid_in with sof goes to FILL with cnt=1.
  - valid_in without sof is ignored.
- FILL (cnt < HALF):
  - On each valid_in, buf_wr=1 and buf_rd=1; the read returns the previous frame's difference.
  - If pend=1, out_sel=1 and a difference beat is emitted.
  - At cnt reaching HALF, go to CALC.
- CALC (cnt >= HALF):
  - On each valid_in, buf_rd=1, bfly_en=1 and buf_wr=1 (the difference is written back).
  - out_sel=0, and the sum is emitted.
  - tw_addr = cnt-HALF, registered, aligned to the multiplier input.
  - On the last beat, set pend and go to FILL.
- Any state, flush=1 with pend=1: go to FLUSH.
- FLUSH:
  - Emit one difference beat per cycle without valid_in (buf_rd=1, out_sel=1) for the remaining pending beats.
  - Then clear pend and go to IDLE.
  - valid_in during FLUSH is dropped.
- sof handling:
  - sof with valid_in while cnt != 0 sets err_sync and restarts the frame: cnt=1, state FILL.
  - If pend=1 at that point, pend is cleared and the un-emitted differences are discarded.
- frame_done pulses with the HALF-th difference beat of each frame.
- A flush received when pend=0 is ignored.

## Timing
- Reset values:
  - buf_wr, buf_rd, bfly_en, out_sel, valid_out, frame_done, busy, err_sync = 0.
  - tw_addr, frame_cnt, cnt = 0.
  - pend = 0, state IDLE.
- The strobes buf_wr, buf_rd and bfly_en are combinational, active in the same cycle as the qualifying valid_in beat.
- valid_out, out_sel and frame_done are delayed BFLY_LAT cycles from the beat that caused them, via a shift pipeline. The FLUSH path uses the same delay.
- If valid_in and flush arrive in the same cycle while in FILL with pend=1, the valid_in beat is processed first. FLUSH starts the next cycle.
- Reset mid-frame aborts immediately. The pipeline clears, and in-flight valid_out beats are lost.
- Gaps in valid_in hold cnt, tw_addr and pend. No timeout applies.

## Configuration
- BFLY_CTRL_STATS_EN defined:
  - frame_cnt increments on each frame_done, saturating at 16'hFFFF.
  - frame_cnt is cleared only by reset.
- BFLY_CTRL_STATS_EN undefined: frame_cnt is tied to 0 and its counter logic is not synthesised.

## Test plan
All scenarios use the default parameters (COUNT=32, HALF=16, BFLY_LAT=1).
- Single frame, then flush:
  - sof plus 32 continuous valid_in beats, then flush.
  - Beats 0-15: buf_wr=1 and no valid_out.
  - Beats 16-31: bfly_en=1, tw_addr sequence 0..15, 16 valid_out with out_sel=0, one cycle late.
  - Then 16 consecutive valid_out with out_sel=1.
  - frame_done on the last of those beats; busy drops after it.
- Back-to-back frames:
  - Two sofs, 64 beats, no gaps.
  - Frame 2 beats 0-15 emit frame 1's differences (out_sel=1).
  - frame_done fires once at frame 2 beat 15, plus 1 cycle.
- Gapped input: valid_in toggles every other cycle for one frame. Output pattern and tw_addr are identical to the continuous case, only stretched; cnt holds in the idle cycles.
- Misaligned sof:
  - sof at cnt=10.
  - err_sync=1 stays set; cnt restarts at 1; no frame_done for the aborted frame.
- Reset mid-CALC: rstn low at cnt=20. All outputs read 0 during reset and after release; state IDLE.
- BFLY_CTRL_STATS_EN: three flushed frames give frame_cnt=3. Without the macro, frame_cnt stays 0.
